sync_fifo_gen: RTL

Parametrised single-clock FIFO: the next generation of the team's 8×16 synchronous FIFO. It adds configurable data width and depth, correct simultaneous read/write accounting, programmable almost-full/almost-empty thresholds, an occupancy output, overflow/underflow error pulses and an optional show-ahead (first-word-fall-through) read mode. It sits between any two same-clock producer/consumer blocks in the datapath.

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/sync_fifo_gen_if.sv | 36 +++
 rtl/sync_fifo_gen_dpram.sv | 28 ++
 rtl/sync_fifo_gen.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
// Defaults reproduce the original 8x16 FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_gen_if.sv
// Producer/consumer bundle for sync_fifo_gen.
// The FIFO takes the slave side; the block that feeds and drains it takes the master side.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int ADDR_W = clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, rd_valid, empty, full, almost_empty, almost_full,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, rd_valid, empty, full, almost_empty, almost_full,
           level, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_gen_dpram.sv
// FIFO storage: DEPTH x DATA_W array, synchronous write, asynchronous read.
// Contents are never reset; the top decides which words are meaningful.
module fifo_dpram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO: pointers, occupancy counter, registered flags,
// error pulses, and either a registered or a show-ahead read path.
module sync_fifo_gen
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit SHOW_AHEAD = 1'b0
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_AF   = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0]  LVL_AE   = LVL_W'(AE_LEVEL);
  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Acceptance looks only at the registered flags, so a simultaneous read
  // never frees a slot for a write in the same cycle (and vice versa).
  always_comb begin
    wr_acc   = bus.wr_en & ~full_q;
    rd_acc   = bus.rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    empty_d = (level_d == '0);
    full_d  = (level_d == LVL_FULL);
    ae_d    = (level_d <= LVL_AE);
    af_d    = (level_d >= LVL_AF);
    ovf_d   = bus.wr_en & full_q;
    unf_d   = bus.rd_en & empty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  if (SHOW_AHEAD == 1'b0) begin : g_reg_read
    logic [DATA_W-1:0] dout_q;
    logic              rv_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        rv_q   <= 1'b0;
      end else begin
        rv_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= mem_rdata;
        end
      end
    end

    assign bus.data_out = dout_q;
    assign bus.rd_valid = rv_q;
  end else begin : g_show_ahead
    // Masking while empty keeps stale memory words off the bus after reset.
    assign bus.data_out = empty_q ? '0 : mem_rdata;
    assign bus.rd_valid = ~empty_q;
  end

  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule
